bcd2bin_seq: RTL

BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

---
 rtl/bcd2bin_seq_pkg.sv | 18 +
 rtl/bcd_digit_adj.sv | 9 +
 rtl/bcd2bin_seq.sv | 117 +++++++++++
 3 files changed

// File: rtl/bcd2bin_seq_pkg.sv
// Shared state encoding and sizing helper for the sequential BCD-to-binary converter.
package bcd2bin_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Ceiling log2: number of bits needed to hold values 0..v-1.
    function automatic int clogb2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: a digit of 8 or more is reduced by 3.
module bcd_digit_adj (
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    assign d_out = (d_in >= 4'd8) ? (d_in - 4'd3) : d_in;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter: one right shift per cycle over a
// {bcd, bin} working register with per-digit correction, valid/ready on both sides.
module bcd2bin_seq
    import bcd2bin_seq_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = clogb2(BIN_W + 1);

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_out_q, bin_out_d;
    logic               err_q, err_d;

    logic [BCD_W-1:0]   sh_bcd, adj_bcd;
    logic [BIN_W-1:0]   sh_bin;
    logic               nib_err;

    // The bcd LSB falls into the bin MSB; a 0 enters the bcd MSB.
    assign sh_bcd = bcd_q >> 1;
    assign sh_bin = {bcd_q[0], bin_q[BIN_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_in  (sh_bcd[4*g +: 4]),
            .d_out (adj_bcd[4*g +: 4])
        );
    end

    always_comb begin
        nib_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) nib_err = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        bin_out_d = bin_out_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (nib_err) begin
                        // Malformed input skips conversion entirely.
                        state_d   = ST_DONE;
                        err_d     = 1'b1;
                        bin_out_d = '0;
                    end else begin
                        state_d = ST_SHIFT;
                        bcd_d   = bcd_in;
                        bin_d   = '0;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                    end
                end
            end
            ST_SHIFT: begin
                bcd_d = adj_bcd;
                bin_d = sh_bin;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d   = ST_DONE;
                    bin_out_d = sh_bin;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            bin_out_q <= bin_out_d;
            err_q     <= err_d;
        end
    end

    assign in_ready  = rst && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign bin_out   = bin_out_q;
    assign err       = err_q;

endmodule
